operand_unpack_pipe: RTL and testbench
======================================

// Module: operand_unpack_pipe
// PURPOSE
// Parametrised, 2-stage pipelined IEEE-754 operand unpacker for the FP adder datapath.
// Accepts an operand pair (x, y) over valid/ready and classifies each (zero/subnormal/inf/NaN).
// Inserts hidden bits, orders operands by magnitude (big/small), and emits the saturated
// alignment shift. Sits between the FPU input interface and the align/add stage.
// PARAMETERS
// EXP_W   8   exponent width (5 half, 8 single, 11 double)
// FRAC_W  23  stored fraction width (10 half, 23 single, 52 double)
// (local) W = 1+EXP_W+FRAC_W; SHIFT_MAX = FRAC_W+3; SHIFT_W = $clog2(SHIFT_MAX+1)
// PORTS
// clk_i         in   1         clock, all logic on rising edge
// rst_i         in   1         synchronous, active-high reset
// in_valid_i    in   1         x_i/y_i valid
// in_ready_o    out  1         unit accepts pair this cycle
// x_i, y_i      in   W         packed operands {sign, exp, frac}
// out_valid_o   out  1         result valid
// out_ready_i   in   1         downstream accepts result
// big_sign_o    out  1         sign of larger-magnitude operand
// small_sign_o  out  1         sign of smaller-magnitude operand
// big_exp_o     out  EXP_W     effective exponent of larger operand
// big_mant_o    out  FRAC_W+1  {hidden, frac} of larger operand
// small_mant_o  out  FRAC_W+1  {hidden, frac} of smaller operand
// exp_shift_o   out  SHIFT_W   right-shift to apply to small_mant_o
// swapped_o     out  1         1 = y is the larger operand
// x_class_o     out  4         {nan, inf, zero, subnormal} for x
// y_class_o     out  4         same for y
// BEHAVIOUR
// - Reset: out_valid_o=0; all data/class outputs=0; both stage valids cleared; in_ready_o=0
//   while rst_i high, 1 on the first cycle after. Reset mid-stream drops all in-flight pairs.
// - Pipeline: S1 registers decoded fields/class; S2 registers compare/swap/shift results.
//   Latency 2 cycles from accept to out_valid_o with no stall; throughput 1 pair/cycle.
// - Handshake: transfer on valid&ready on either side. s2_ready = ~out_valid_o | out_ready_i;
//   in_ready_o = ~s1_valid | s2_ready (combinational). A stage loads only when advancing.
//   Stalled outputs hold stable; out_valid_o never drops without out_ready_i.
// - Decode: hidden = (exp!=0); eff_exp = (exp==0) ? 1 : exp; mant = {hidden, frac}.
//   zero = exp==0 & frac==0; subnormal = exp==0 & frac!=0; inf = exp=all-1 & frac==0;
//   nan = exp=all-1 & frac!=0. Exactly one or none of the bits set.
// - Order: x is big if {eff_exp_x, mant_x} >= {eff_exp_y, mant_y} (ties -> x, swapped_o=0).
// - Shift: exp_shift_o = min(|eff_exp_x - eff_exp_y|, SHIFT_MAX). Difference computed
//   at EXP_W+1 bits, no wrap.
// - Inf/NaN pass through unchanged; class flags are authoritative for the special-case path.
// - Simultaneous accept and emit in one cycle is legal and loses no data.
// TESTING
// 1. x=3fc00000, y=4500001a -> after 2 cycles: swapped=1, big_exp=8a, big_mant=80001a,
//    small_mant=c00000, exp_shift=0b.
// 2. x=40000000, y=40400000 (equal exp) -> swapped=1, big_mant=c00000, small_mant=800000,
//    exp_shift=0.
// 3. x=00000001, y=80000000 -> x_class=0001, y_class=0010, swapped=0, big_exp=01,
//    small_sign=1, exp_shift=0.
// 4. x=7f000000, y=3f800000 -> raw diff 0x7f is saturated: exp_shift=1a, swapped=0.
// 5. x=7fffffff, y=ff800000 -> x_class=1000, y_class=0100, big_mant=ffffff, swapped=0,
//    small_sign=1.
// 6. Hold out_ready_i=0 and offer 3 pairs -> 2 accepted, then in_ready_o=0 with outputs
//    stable. Release -> results drain in order, no loss or duplicates. Assert rst_i
//    mid-stream -> out_valid_o=0 next cycle.

Source files
------------

// File: rtl/operand_unpack_pipe_if.sv
// operand_unpack_pipe_if
// Bundles the operand-pair handshake and the unpacked result bus of the
// FP adder operand unpacker.
//   master : the side that offers operand pairs and accepts results
//            (drives in_valid_i, x_i, y_i, out_ready_i)
//   slave  : the unpacker itself (drives in_ready_o and every result field)
// Packed operands are {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}.
interface operand_unpack_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W         = 1 + EXP_W + FRAC_W;
    localparam int SHIFT_MAX = FRAC_W + 3;
    localparam int SHIFT_W   = $clog2(SHIFT_MAX + 1);

    logic                in_valid_i;
    logic                in_ready_o;
    logic [W-1:0]        x_i;
    logic [W-1:0]        y_i;

    logic                out_valid_o;
    logic                out_ready_i;
    logic                big_sign_o;
    logic                small_sign_o;
    logic [EXP_W-1:0]    big_exp_o;
    logic [FRAC_W:0]     big_mant_o;
    logic [FRAC_W:0]     small_mant_o;
    logic [SHIFT_W-1:0]  exp_shift_o;
    logic                swapped_o;
    logic [3:0]          x_class_o;
    logic [3:0]          y_class_o;

    modport master (
        output in_valid_i, x_i, y_i, out_ready_i,
        input  in_ready_o, out_valid_o, big_sign_o, small_sign_o, big_exp_o,
               big_mant_o, small_mant_o, exp_shift_o, swapped_o,
               x_class_o, y_class_o
    );

    modport slave (
        input  in_valid_i, x_i, y_i, out_ready_i,
        output in_ready_o, out_valid_o, big_sign_o, small_sign_o, big_exp_o,
               big_mant_o, small_mant_o, exp_shift_o, swapped_o,
               x_class_o, y_class_o
    );
endinterface

// File: rtl/operand_unpack_pipe.sv
// operand_unpack_pipe
// Two-stage pipelined IEEE-754 operand unpacker feeding the align/add stage
// of the FP adder. Stage 1 decodes each operand (class flags, effective
// exponent, mantissa with hidden bit). Stage 2 orders the pair by magnitude
// and produces the saturated alignment shift for the smaller mantissa.
// Ports:
//   clk_i  : clock, everything on the rising edge
//   rst_i  : synchronous active-high reset, drops all in-flight pairs
//   bus    : operand_unpack_pipe_if.slave
//              in_valid_i/in_ready_o/x_i/y_i      operand pair handshake
//              out_valid_o/out_ready_i            result handshake
//              big_*/small_*/exp_shift_o/swapped_o ordered, unpacked pair
//              x_class_o/y_class_o                {nan, inf, zero, subnormal}
module operand_unpack_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    operand_unpack_pipe_if.slave  bus
);
    localparam int W         = 1 + EXP_W + FRAC_W;
    localparam int SHIFT_MAX = FRAC_W + 3;
    localparam int SHIFT_W   = $clog2(SHIFT_MAX + 1);

    // Class flags are one-hot or all-zero for a normal number. Inf/NaN keep
    // their raw fraction so the special-case path can inspect the payload.
    function automatic logic [3:0] classify(input logic [EXP_W-1:0]  e,
                                            input logic [FRAC_W-1:0] f);
        logic e_zero;
        logic e_ones;
        logic f_zero;
        e_zero = (e == '0);
        e_ones = &e;
        f_zero = (f == '0);
        return {e_ones & ~f_zero, e_ones & f_zero, e_zero & f_zero, e_zero & ~f_zero};
    endfunction

    // Subnormals behave as if their exponent were 1, without the hidden bit.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    logic [EXP_W-1:0]  x_exp;
    logic [EXP_W-1:0]  y_exp;
    logic [FRAC_W-1:0] x_frac;
    logic [FRAC_W-1:0] y_frac;

    assign x_exp  = bus.x_i[W-2:FRAC_W];
    assign y_exp  = bus.y_i[W-2:FRAC_W];
    assign x_frac = bus.x_i[FRAC_W-1:0];
    assign y_frac = bus.y_i[FRAC_W-1:0];

    logic              s1_valid;
    logic              s1_sign_x;
    logic              s1_sign_y;
    logic [EXP_W-1:0]  s1_exp_x;
    logic [EXP_W-1:0]  s1_exp_y;
    logic [FRAC_W:0]   s1_mant_x;
    logic [FRAC_W:0]   s1_mant_y;
    logic [3:0]        s1_class_x;
    logic [3:0]        s1_class_y;

    logic              out_valid;
    logic              big_sign;
    logic              small_sign;
    logic [EXP_W-1:0]  big_exp;
    logic [FRAC_W:0]   big_mant;
    logic [FRAC_W:0]   small_mant;
    logic [SHIFT_W-1:0] exp_shift;
    logic              swapped;
    logic [3:0]        x_class;
    logic [3:0]        y_class;

    logic s2_ready;
    logic s1_ready;

    // A stage may take new data when it is empty or its content moves on
    // this same cycle, which gives full throughput with back-pressure.
    assign s2_ready = ~out_valid | bus.out_ready_i;
    assign s1_ready = ~s1_valid | s2_ready;

    assign bus.in_ready_o = ~rst_i & s1_ready;

    // Magnitude order compares {eff_exp, mant} as one unsigned key, so equal
    // keys keep x as the big operand. The exponent distance is taken one bit
    // wider than the exponent so it can never wrap before saturating.
    logic              x_big;
    logic [EXP_W:0]    exp_diff;
    logic [SHIFT_W-1:0] shift_sat;

    always_comb begin
        x_big    = {s1_exp_x, s1_mant_x} >= {s1_exp_y, s1_mant_y};
        exp_diff = (s1_exp_x >= s1_exp_y) ? ({1'b0, s1_exp_x} - {1'b0, s1_exp_y})
                                          : ({1'b0, s1_exp_y} - {1'b0, s1_exp_x});
        if (exp_diff > (EXP_W+1)'(SHIFT_MAX)) begin
            shift_sat = SHIFT_W'(SHIFT_MAX);
        end else begin
            shift_sat = SHIFT_W'(exp_diff);
        end
    end

    // Both stages live in one block: valids advance whenever the next stage
    // can take them, data registers load only on an actual transfer so a
    // stalled result stays stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid   <= 1'b0;
            s1_sign_x  <= 1'b0;
            s1_sign_y  <= 1'b0;
            s1_exp_x   <= '0;
            s1_exp_y   <= '0;
            s1_mant_x  <= '0;
            s1_mant_y  <= '0;
            s1_class_x <= '0;
            s1_class_y <= '0;
            out_valid  <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_exp    <= '0;
            big_mant   <= '0;
            small_mant <= '0;
            exp_shift  <= '0;
            swapped    <= 1'b0;
            x_class    <= '0;
            y_class    <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= bus.in_valid_i;
            end
            if (s1_ready && bus.in_valid_i) begin
                s1_sign_x  <= bus.x_i[W-1];
                s1_sign_y  <= bus.y_i[W-1];
                s1_exp_x   <= eff_exp(x_exp);
                s1_exp_y   <= eff_exp(y_exp);
                s1_mant_x  <= {|x_exp, x_frac};
                s1_mant_y  <= {|y_exp, y_frac};
                s1_class_x <= classify(x_exp, x_frac);
                s1_class_y <= classify(y_exp, y_frac);
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s2_ready && s1_valid) begin
                big_sign   <= x_big ? s1_sign_x : s1_sign_y;
                small_sign <= x_big ? s1_sign_y : s1_sign_x;
                big_exp    <= x_big ? s1_exp_x  : s1_exp_y;
                big_mant   <= x_big ? s1_mant_x : s1_mant_y;
                small_mant <= x_big ? s1_mant_y : s1_mant_x;
                exp_shift  <= shift_sat;
                swapped    <= ~x_big;
                x_class    <= s1_class_x;
                y_class    <= s1_class_y;
            end
        end
    end

    assign bus.out_valid_o  = out_valid;
    assign bus.big_sign_o   = big_sign;
    assign bus.small_sign_o = small_sign;
    assign bus.big_exp_o    = big_exp;
    assign bus.big_mant_o   = big_mant;
    assign bus.small_mant_o = small_mant;
    assign bus.exp_shift_o  = exp_shift;
    assign bus.swapped_o    = swapped;
    assign bus.x_class_o    = x_class;
    assign bus.y_class_o    = y_class;
endmodule

// File: tb/tb_operand_unpack_pipe.sv
// tb_operand_unpack_pipe
// Self-checking bench for operand_unpack_pipe (single precision). A
// reference model computes each expected result from the operand values with
// plain integer arithmetic; a scoreboard queue holds results of accepted
// pairs and a negedge compare process checks every emitted result, plus
// output stability during stalls.
module tb_operand_unpack_pipe;
    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int W         = 1 + EXP_W + FRAC_W;
    localparam int SHIFT_MAX = FRAC_W + 3;
    localparam int SHIFT_W   = $clog2(SHIFT_MAX + 1);

    typedef struct packed {
        logic               big_sign;
        logic               small_sign;
        logic [EXP_W-1:0]   big_exp;
        logic [FRAC_W:0]    big_mant;
        logic [FRAC_W:0]    small_mant;
        logic [SHIFT_W-1:0] exp_shift;
        logic               swapped;
        logic [3:0]         x_class;
        logic [3:0]         y_class;
    } res_t;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    res_t exp_q[$];
    bit   stall_prev = 0;
    res_t stall_snap;

    operand_unpack_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus();

    operand_unpack_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unpack with integers, order by the real magnitude
    // relation (exponent first, then mantissa), clamp the exponent distance.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        int     ex, ey, fx, fy, effx, effy, mx, my, d;
        longint kx, ky;
        bit     x_big;
        int     all_ones;
        all_ones = (1 << EXP_W) - 1;
        ex   = int'(x[W-2:FRAC_W]);
        ey   = int'(y[W-2:FRAC_W]);
        fx   = int'(x[FRAC_W-1:0]);
        fy   = int'(y[FRAC_W-1:0]);
        effx = (ex == 0) ? 1 : ex;
        effy = (ey == 0) ? 1 : ey;
        mx   = fx + ((ex != 0) ? (1 << FRAC_W) : 0);
        my   = fy + ((ey != 0) ? (1 << FRAC_W) : 0);
        kx   = longint'(effx) * (longint'(1) << (FRAC_W + 1)) + longint'(mx);
        ky   = longint'(effy) * (longint'(1) << (FRAC_W + 1)) + longint'(my);
        x_big = (kx >= ky);
        d = effx - effy;
        if (d < 0) d = -d;
        if (d > SHIFT_MAX) d = SHIFT_MAX;
        r.big_sign   = x_big ? x[W-1] : y[W-1];
        r.small_sign = x_big ? y[W-1] : x[W-1];
        r.big_exp    = EXP_W'(x_big ? effx : effy);
        r.big_mant   = (FRAC_W+1)'(x_big ? mx : my);
        r.small_mant = (FRAC_W+1)'(x_big ? my : mx);
        r.exp_shift  = SHIFT_W'(d);
        r.swapped    = !x_big;
        r.x_class    = (ex == all_ones) ? ((fx != 0) ? 4'b1000 : 4'b0100)
                     : (ex == 0)        ? ((fx == 0) ? 4'b0010 : 4'b0001) : 4'b0000;
        r.y_class    = (ey == all_ones) ? ((fy != 0) ? 4'b1000 : 4'b0100)
                     : (ey == 0)        ? ((fy == 0) ? 4'b0010 : 4'b0001) : 4'b0000;
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.big_sign   = bus.big_sign_o;
        r.small_sign = bus.small_sign_o;
        r.big_exp    = bus.big_exp_o;
        r.big_mant   = bus.big_mant_o;
        r.small_mant = bus.small_mant_o;
        r.exp_shift  = bus.exp_shift_o;
        r.swapped    = bus.swapped_o;
        r.x_class    = bus.x_class_o;
        r.y_class    = bus.y_class_o;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        case ($urandom_range(0, 7))
            0:       e = '0;
            1:       e = '1;
            2:       e = EXP_W'(124 + $urandom_range(0, 6));
            default: e = EXP_W'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? '0 : FRAC_W'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Scoreboard: accepted pairs push their model result, emitted results
    // pop and compare in order; a stalled result must stay valid and stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 0;
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 128'(dut_res()), 128'(1'b0));
                    if (dut_res() == '0) begin
                        mismatched++;
                        $display("[TB] FAIL unexpected_result: out_valid with no pending pair");
                    end
                end else begin
                    checkOutput("result", 128'(dut_res()), 128'(exp_q.pop_front()));
                end
            end
            if (stall_prev) begin
                checkOutput("stall_valid", 128'(bus.out_valid_o), 128'(1'b1));
                checkOutput("stall_hold", 128'(dut_res()), 128'(stall_snap));
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            stall_snap = dut_res();
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(model(bus.x_i, bus.y_i));
            end
        end
    end

    // Offer one pair and hold it until accepted. Call just after a posedge;
    // returns just after the posedge that took the pair.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
        bit done;
        done = 0;
        bus.in_valid_i = 1'b1;
        bus.x_i = x;
        bus.y_i = y;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready_o;
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL accept_timeout: pair %0h/%0h not accepted, required accept within 50 cycles", x, y);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid_o) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        idle(2);
        checkOutput("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [W-1:0] tx[5];
        logic [W-1:0] ty[5];
        res_t         tr[5];
        bit           fire;

        tx[0] = 32'h3fc00000; ty[0] = 32'h4500001a;
        tr[0] = '{1'b0, 1'b0, 8'h8a, 24'h80001a, 24'hc00000, 5'h0b, 1'b1, 4'h0, 4'h0};
        tx[1] = 32'h40000000; ty[1] = 32'h40400000;
        tr[1] = '{1'b0, 1'b0, 8'h80, 24'hc00000, 24'h800000, 5'h00, 1'b1, 4'h0, 4'h0};
        tx[2] = 32'h00000001; ty[2] = 32'h80000000;
        tr[2] = '{1'b0, 1'b1, 8'h01, 24'h000001, 24'h000000, 5'h00, 1'b0, 4'h1, 4'h2};
        tx[3] = 32'h7f000000; ty[3] = 32'h3f800000;
        tr[3] = '{1'b0, 1'b0, 8'hfe, 24'h800000, 24'h800000, 5'h1a, 1'b0, 4'h0, 4'h0};
        tx[4] = 32'h7fffffff; ty[4] = 32'hff800000;
        tr[4] = '{1'b0, 1'b1, 8'hff, 24'hffffff, 24'h800000, 5'h00, 1'b0, 4'h8, 4'h4};

        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.x_i         = '0;
        bus.y_i         = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        idle(2);
        @(negedge clk);
        checkOutput("reset_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
        checkOutput("reset_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
        checkOutput("reset_outputs", 128'(dut_res()), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
        @(posedge clk);
        #1;

        // Hand-computed cases pin the model; the scoreboard checks the DUT.
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("model_case%0d", i + 1), 128'(model(tx[i], ty[i])), 128'(tr[i]));
            applyStimulus(tx[i], ty[i]);
            if (i == 0) begin
                @(negedge clk);
                checkOutput("latency_cycle1", 128'(bus.out_valid_o), 128'(1'b0));
                @(negedge clk);
                checkOutput("latency_cycle2", 128'(bus.out_valid_o), 128'(1'b1));
                @(posedge clk);
                #1;
            end
            idle(3);
        end
        drain();

        // Back-pressure: two pairs fill the pipe, the third must wait.
        bus.out_ready_i = 1'b0;
        applyStimulus(tx[0], ty[0]);
        applyStimulus(tx[3], ty[3]);
        bus.in_valid_i = 1'b1;
        bus.x_i = tx[4];
        bus.y_i = ty[4];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
            checkOutput("stall_out_valid", 128'(bus.out_valid_o), 128'(1'b1));
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        applyStimulus(tx[4], ty[4]);
        drain();

        // Reset in the middle of a stream drops everything in flight.
        applyStimulus(tx[1], ty[1]);
        applyStimulus(tx[2], ty[2]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
        checkOutput("midreset_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_dropped", 128'(bus.out_valid_o), 128'(1'b0));
        end
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure; pairs hold until taken.
        bus.in_valid_i = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            fire = bus.in_valid_i && bus.in_ready_o;
            @(posedge clk);
            #1;
            if (!bus.in_valid_i || fire) begin
                bus.in_valid_i = ($urandom_range(0, 9) < 7);
                bus.x_i = rand_operand();
                bus.y_i = rand_operand();
            end
            bus.out_ready_i = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion before 200000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
